// File: rtl/ring_phase_monitor_if.sv
// Signal bundle between a one-hot ring counter and its phase monitor.
// The master drives the ring sample and error clear; the slave returns phase and health status.
interface ring_phase_monitor_if #(
   parameter int WIDTH = 4,
   parameter int REV_W = 8
);
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] ring_in;
   logic             clr_err;
   logic [PW-1:0]    phase;
   logic             phase_valid;
   logic [REV_W-1:0] rev_count;
   logic             rev_wrap;
   logic             locked;
   logic             err_onehot;
   logic             err_seq;
   logic             err_stuck;

   modport master (
      output ring_in, clr_err,
      input  phase, phase_valid, rev_count, rev_wrap, locked,
             err_onehot, err_seq, err_stuck
   );

   modport slave (
      input  ring_in, clr_err,
      output phase, phase_valid, rev_count, rev_wrap, locked,
             err_onehot, err_seq, err_stuck
   );
endinterface

// File: rtl/ring_phase_monitor.sv
// Phase monitor for a one-hot ring counter: encodes the phase, counts revolutions,
// and flags illegal codes, out-of-order steps and stalls once the ring is locked.
module ring_phase_monitor #(
   parameter int WIDTH       = 4,
   parameter int REV_W       = 8,
   parameter int LOCK_CNT    = 3,
   parameter int STUCK_LIMIT = 4
) (
   input logic                 clk,
   input logic                 reset,
   ring_phase_monitor_if.slave mon
);
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(STUCK_LIMIT + 1);

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_LOCKED   = 2'd1;
   localparam logic [1:0] ST_FAULT    = 2'd2;

   function automatic logic onehot(input logic [WIDTH-1:0] v);
      return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
   endfunction

   function automatic logic [PW-1:0] encode(input logic [WIDTH-1:0] v);
      logic [PW-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) idx = PW'(i);
      end
      return idx;
   endfunction

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   logic [WIDTH-1:0] cur_p1;
   logic [PW-1:0]    phase_p1;
   logic             vld_p1;
   logic [1:0]       state;
   logic [LW-1:0]    lock_cnt;
   logic [SW-1:0]    stuck_cnt;
   logic [REV_W-1:0] rev_cnt;
   logic             rev_wrap_q;
   logic             err_onehot_q;
   logic             err_seq_q;
   logic             err_stuck_q;

   logic new_oh;
   logic cur_oh;
   logic same;
   logic legal_adv;
   logic onehot_bad;
   logic seq_bad;
   logic stall;
   logic wrap_adv;
   logic lock_err;
   logic in_locked;
   logic in_fault;
   logic lock_hit;

   // Stage p0: classify the incoming sample against the previous one
   assign new_oh     = onehot(mon.ring_in);
   assign cur_oh     = onehot(cur_p1);
   assign same       = (mon.ring_in == cur_p1);
   assign legal_adv  = new_oh && cur_oh && (mon.ring_in == rotl(cur_p1));
   assign onehot_bad = !new_oh;
   assign seq_bad    = new_oh && cur_oh && !same && !legal_adv;
   assign stall      = same && (stuck_cnt == SW'(STUCK_LIMIT - 1));
   assign wrap_adv   = legal_adv && cur_p1[WIDTH-1] && mon.ring_in[0];
   assign lock_err   = onehot_bad || seq_bad || stall;
   assign in_locked  = (state == ST_LOCKED);
   assign in_fault   = (state == ST_FAULT);
   assign lock_hit   = (state == ST_UNLOCKED) && legal_adv &&
                       (lock_cnt == LW'(LOCK_CNT - 1));

   // Stage p1: registered sample, phase and health state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_p1   <= '0;
         phase_p1 <= '0;
         vld_p1   <= 1'b0;
      end else begin
         cur_p1 <= mon.ring_in;
         vld_p1 <= new_oh;
         if (new_oh) phase_p1 <= encode(mon.ring_in);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stuck_cnt <= '0;
      end else if ((in_fault && mon.clr_err) || lock_hit) begin
         stuck_cnt <= '0;
      end else if (same) begin
         if (stuck_cnt != SW'(STUCK_LIMIT)) stuck_cnt <= stuck_cnt + SW'(1);
      end else begin
         stuck_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_UNLOCKED;
         lock_cnt <= '0;
      end else begin
         case (state)
            ST_UNLOCKED: begin
               if (lock_hit) begin
                  state    <= ST_LOCKED;
                  lock_cnt <= LW'(LOCK_CNT);
               end else if (legal_adv) begin
                  lock_cnt <= lock_cnt + LW'(1);
               end else if (same || onehot_bad || seq_bad) begin
                  lock_cnt <= '0;
               end
            end
            ST_LOCKED: begin
               if (lock_err) state <= ST_FAULT;
            end
            ST_FAULT: begin
               if (mon.clr_err) begin
                  state    <= ST_UNLOCKED;
                  lock_cnt <= '0;
               end
            end
            default: begin
               state    <= ST_UNLOCKED;
               lock_cnt <= '0;
            end
         endcase
      end
   end

   // A new error while locked beats a coincident clear request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_onehot_q <= 1'b0;
         err_seq_q    <= 1'b0;
         err_stuck_q  <= 1'b0;
      end else if (in_locked && lock_err) begin
         err_onehot_q <= err_onehot_q | onehot_bad;
         err_seq_q    <= err_seq_q | seq_bad;
         err_stuck_q  <= err_stuck_q | stall;
      end else if (mon.clr_err) begin
         err_onehot_q <= 1'b0;
         err_seq_q    <= 1'b0;
         err_stuck_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rev_cnt    <= '0;
         rev_wrap_q <= 1'b0;
      end else if (in_locked && wrap_adv) begin
         rev_cnt    <= rev_cnt + REV_W'(1);
         rev_wrap_q <= &rev_cnt;
      end else begin
         rev_wrap_q <= 1'b0;
      end
   end

   assign mon.phase       = phase_p1;
   assign mon.phase_valid = vld_p1;
   assign mon.rev_count   = rev_cnt;
   assign mon.rev_wrap    = rev_wrap_q;
   assign mon.locked      = in_locked;
   assign mon.err_onehot  = err_onehot_q;
   assign mon.err_seq     = err_seq_q;
   assign mon.err_stuck   = err_stuck_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed and randomized bench for ring_phase_monitor; two instances (REV_W=8 and REV_W=2)
// share one stimulus stream and are checked against a behavioural model every cycle.
module tb_ring_phase_monitor;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ring;
   logic       clr;

   always #5 clk = ~clk;

   ring_phase_monitor_if #(.WIDTH(4), .REV_W(8)) bus8 ();
   ring_phase_monitor_if #(.WIDTH(4), .REV_W(2)) bus2 ();

   assign bus8.ring_in = ring;
   assign bus8.clr_err = clr;
   assign bus2.ring_in = ring;
   assign bus2.clr_err = clr;

   ring_phase_monitor #(.WIDTH(4), .REV_W(8), .LOCK_CNT(3), .STUCK_LIMIT(4)) dut8 (
      .clk   (clk),
      .reset (reset),
      .mon   (bus8)
   );

   ring_phase_monitor #(.WIDTH(4), .REV_W(2), .LOCK_CNT(3), .STUCK_LIMIT(4)) dut2 (
      .clk   (clk),
      .reset (reset),
      .mon   (bus2)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state, expressed as phase indices and run lengths
   logic [3:0] m_cur;
   int         m_phase;
   bit         m_pv;
   int         m_rev8, m_rev2;
   bit         m_wrap8, m_wrap2;
   bit         m_locked, m_fault;
   bit         m_eo, m_es, m_est;
   int         m_lock_run, m_same_run;
   logic [3:0] cur_r;

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit is_oh(input logic [3:0] v);
      return $countones(v) == 1;
   endfunction

   function automatic logic [3:0] next_of(input logic [3:0] v);
      if (!is_oh(v)) return 4'b0001;
      return 4'(1 << ((idx_of(v) + 1) % 4));
   endfunction

   task automatic model_reset();
      m_cur = 4'b0000; m_phase = 0; m_pv = 0;
      m_rev8 = 0; m_rev2 = 0; m_wrap8 = 0; m_wrap2 = 0;
      m_locked = 0; m_fault = 0; m_eo = 0; m_es = 0; m_est = 0;
      m_lock_run = 0; m_same_run = 0;
   endtask

   task automatic model_step(input logic [3:0] r, input bit c);
      bit oh, coh, same, legal, seqbad, stall, wrap, err;
      oh     = is_oh(r);
      coh    = is_oh(m_cur);
      same   = (r == m_cur);
      legal  = oh && coh && (idx_of(r) == (idx_of(m_cur) + 1) % 4);
      seqbad = oh && coh && !same && !legal;
      stall  = same && (m_same_run + 1 == 4);
      wrap   = legal && (idx_of(m_cur) == 3);
      err    = !oh || seqbad || stall;
      m_wrap8 = 0;
      m_wrap2 = 0;
      m_same_run = same ? ((m_same_run < 4) ? m_same_run + 1 : 4) : 0;
      if (m_locked) begin
         if (wrap) begin
            m_rev8 = (m_rev8 + 1) % 256;
            m_rev2 = (m_rev2 + 1) % 4;
            m_wrap8 = (m_rev8 == 0);
            m_wrap2 = (m_rev2 == 0);
         end
         if (err) begin
            m_eo |= !oh;
            m_es |= seqbad;
            m_est |= stall;
            m_locked = 0;
            m_fault = 1;
         end
      end else if (m_fault) begin
         if (c) begin
            m_eo = 0; m_es = 0; m_est = 0;
            m_fault = 0; m_lock_run = 0; m_same_run = 0;
         end
      end else begin
         if (legal) m_lock_run++;
         else if (same || !oh || seqbad) m_lock_run = 0;
         if (m_lock_run == 3) begin
            m_locked = 1;
            m_lock_run = 0;
            m_same_run = 0;
         end
      end
      if (oh) m_phase = idx_of(r);
      m_pv = oh;
      m_cur = r;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("phase",       32'(bus8.phase),       m_phase);
      chk("phase_valid", 32'(bus8.phase_valid), 32'(m_pv));
      chk("rev_count8",  32'(bus8.rev_count),   m_rev8);
      chk("rev_wrap8",   32'(bus8.rev_wrap),    32'(m_wrap8));
      chk("locked",      32'(bus8.locked),      32'(m_locked));
      chk("err_onehot",  32'(bus8.err_onehot),  32'(m_eo));
      chk("err_seq",     32'(bus8.err_seq),     32'(m_es));
      chk("err_stuck",   32'(bus8.err_stuck),   32'(m_est));
      chk("rev_count2",  32'(bus2.rev_count),   m_rev2);
      chk("rev_wrap2",   32'(bus2.rev_wrap),    32'(m_wrap2));
   endtask

   task automatic cycle(input logic [3:0] r, input bit c);
      ring = r;
      clr = c;
      cur_r = r;
      @(posedge clk);
      model_step(r, c);
      #1;
      check_all();
      clr = 1'b0;
   endtask

   task automatic rot(input int n);
      repeat (n) cycle(next_of(cur_r), 1'b0);
   endtask

   task automatic rot_to(input logic [3:0] target);
      for (int k = 0; k < 5; k++) begin
         if (cur_r == target) break;
         rot(1);
      end
   endtask

   task automatic async_reset_check();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_async_rev",    32'(bus8.rev_count), 0);
      chk("rst_async_locked", 32'(bus8.locked),    0);
      ring = 4'b0000;
      cur_r = 4'b0000;
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] nx;
      int         p;
      bit         c;

      reset = 1'b1; ring = 4'b0000; clr = 1'b0; cur_r = 4'b0000;
      model_reset();
      #1 reset = 1'b0;
      #1;
      check_all();
      chk("rst_phase_valid", 32'(bus8.phase_valid), 0);
      #9 reset = 1'b1;

      // Lock and wrap
      cycle(4'b0001, 0);
      cycle(4'b0001, 0);
      cycle(4'b0010, 0);
      chk("not_locked_1", 32'(bus8.locked), 0);
      cycle(4'b0100, 0);
      chk("not_locked_2", 32'(bus8.locked), 0);
      cycle(4'b1000, 0);
      chk("locked_after_3", 32'(bus8.locked), 1);
      chk("rev_before_wrap", 32'(bus8.rev_count), 0);
      cycle(4'b0001, 0);
      chk("rev_first_wrap", 32'(bus8.rev_count), 1);
      chk("phase_wrap", 32'(bus8.phase), 0);
      rot(15);
      chk("rev8_after_4", 32'(bus8.rev_count), 4);
      chk("rev2_wrapped", 32'(bus2.rev_count), 0);

      // Illegal one-hot while locked
      cycle(4'b0110, 0);
      chk("oh_valid_low", 32'(bus8.phase_valid), 0);
      chk("oh_flag", 32'(bus8.err_onehot), 1);
      chk("oh_phase_held", 32'(bus8.phase), 3);
      rot(3);
      chk("oh_flag_sticky", 32'(bus8.err_onehot), 1);
      cycle(next_of(cur_r), 1);
      chk("oh_cleared", 32'(bus8.err_onehot), 0);
      rot(3);
      chk("relock_after_oh", 32'(bus8.locked), 1);

      // Sequence skip, then clear and relock
      rot_to(4'b0001);
      cycle(4'b0010, 0);
      cycle(4'b1000, 0);
      chk("seq_flag", 32'(bus8.err_seq), 1);
      chk("seq_unlock", 32'(bus8.locked), 0);
      cycle(4'b0001, 1);
      chk("seq_cleared", 32'(bus8.err_seq), 0);
      rot(3);
      chk("relock_after_seq", 32'(bus8.locked), 1);

      // Stall: four same edges is an error, two is not
      rot_to(4'b0010);
      cycle(4'b0100, 0);
      repeat (3) cycle(4'b0100, 0);
      chk("stall_not_yet", 32'(bus8.err_stuck), 0);
      cycle(4'b0100, 0);
      chk("stall_flag", 32'(bus8.err_stuck), 1);
      cycle(4'b0100, 1);
      rot(3);
      rot_to(4'b0010);
      cycle(4'b0100, 0);
      repeat (2) cycle(4'b0100, 0);
      cycle(4'b1000, 0);
      chk("short_hold_ok", 32'(bus8.err_stuck), 0);
      chk("short_hold_locked", 32'(bus8.locked), 1);

      // Reset priority: error beats clear, then async reset at rev_count=5
      async_reset_check();
      cycle(4'b0001, 0);
      rot(3);
      chk("relock_post_reset", 32'(bus8.locked), 1);
      cycle(4'b0110, 1);
      chk("err_beats_clr", 32'(bus8.err_onehot), 1);
      cycle(4'b0001, 1);
      rot(3);
      for (int k = 0; k < 40 && m_rev8 != 5; k++) rot(1);
      rot(2);
      chk("rev_at_5", 32'(bus8.rev_count), 5);
      async_reset_check();

      // Randomized ring with occasional holds, skips, corrupt codes and clears
      for (int k = 0; k < 400; k++) begin
         p = $urandom_range(0, 99);
         if (p < 70)      nx = next_of(cur_r);
         else if (p < 80) nx = cur_r;
         else if (p < 87) nx = next_of(next_of(cur_r));
         else if (p < 93) nx = 4'($urandom_range(0, 15));
         else             nx = next_of(cur_r);
         c = ($urandom_range(0, 19) == 0);
         cycle(nx, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
